bcd_updown_counter_seg: RTL

- Parametrised multi-digit BCD up/down counter with registered active-low 7-segment outputs per digit.
- Adds the following to the earlier 4-bit binary counter: configurable digit count and modulus, enable, synchronous parallel load, wrap or saturate at the bounds, a terminal-count pulse and leading-zero blanking.
- Drives the board's multiplexed or static 7-segment display bank directly from the top level.

---
 rtl/bcd_pkg.sv | 59 +++++
 rtl/bcd_digit.sv | 39 +++
 rtl/bcd_updown_counter_seg.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD and 7-segment helpers for the BCD up/down counter
package bcd_pkg;

    localparam int         MAX_DIGITS = 4;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    // Active-low segment pattern, bit7 = a ... bit1 = g, bit0 = dp (dp always off).
    function automatic logic [7:0] seg7(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'd0:    s = 8'h03;
            4'd1:    s = 8'h9F;
            4'd2:    s = 8'h25;
            4'd3:    s = 8'h0D;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h49;
            4'd6:    s = 8'h41;
            4'd7:    s = 8'h1F;
            4'd8:    s = 8'h01;
            4'd9:    s = 8'h09;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Decimal integer to packed BCD, digit 0 in bits [3:0].
    function automatic logic [15:0] to_bcd(input int val);
        logic [15:0] r;
        int          v;
        r = '0;
        v = val;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // True when the lowest 'digits' nibbles are all 0..9.
    function automatic logic bcd_valid(input logic [15:0] v, input int digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Segment image of a zero count, used as the reset value of the display.
    function automatic logic [31:0] seg_zero(input int digits, input logic blank);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) r[8*i +: 8] = (blank && i != 0) ? SEG_BLANK : seg7(4'd0);
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit with load, increment/carry and decrement/borrow
module bcd_digit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  logic [3:0] load_nib,
    output logic [3:0] nib,
    output logic       carry_out,
    output logic       borrow_out
);

    logic [3:0] nib_d;
    logic [3:0] nib_q;

    // Next digit value: load wins, then increment, then decrement.
    always_comb begin
        nib_d = nib_q;
        if (load) begin
            nib_d = load_nib;
        end else if (inc) begin
            nib_d = (nib_q == 4'd9) ? 4'd0 : nib_q + 4'd1;
        end else if (dec) begin
            nib_d = (nib_q == 4'd0) ? 4'd9 : nib_q - 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) nib_q <= 4'd0;
        else        nib_q <= nib_d;
    end

    assign nib        = nib_q;
    assign carry_out  = inc & ~load & (nib_q == 4'd9);
    assign borrow_out = dec & ~load & (nib_q == 4'd0);

endmodule

// File: rtl/bcd_updown_counter_seg.sv
// rtl/bcd_updown_counter_seg.sv - multi-digit BCD up/down counter with registered 7-segment outputs
module bcd_updown_counter_seg
    import bcd_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MAX_VAL = 99,
    parameter bit WRAP    = 1'b1,
    parameter bit BLANK   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  err,
    output logic [8*DIGITS-1:0]   seg
);

    localparam int                  W        = 4 * DIGITS;
    localparam logic [15:0]         MAX_FULL = to_bcd(MAX_VAL);
    localparam logic [W-1:0]        MAX_BCD  = MAX_FULL[W-1:0];
    localparam logic [31:0]         SEG_FULL = seg_zero(DIGITS, BLANK);
    localparam logic [8*DIGITS-1:0] SEG_RST  = SEG_FULL[8*DIGITS-1:0];

    logic [W-1:0]        count_w;
    logic [DIGITS:0]     inc_c;
    logic [DIGITS:0]     dec_c;
    logic                step_up;
    logic                step_dn;
    logic                dig_load;
    logic [W-1:0]        dig_load_val;
    logic                load_ok;
    logic                tc_d, tc_q;
    logic                err_d, err_q;
    logic [8*DIGITS-1:0] seg_d, seg_q;
    logic                lead;
    logic [3:0]          nib;
    logic                unused_chain;

    // A load is accepted only for well-formed BCD not above the configured bound;
    // BCD compares in the same order as the decimal value, so a plain compare suffices.
    assign load_ok = bcd_valid(16'(load_val), DIGITS) && (load_val <= MAX_BCD);

    // Step control: load has priority, then the enabled step with wrap/saturate at the bounds.
    always_comb begin
        step_up      = 1'b0;
        step_dn      = 1'b0;
        dig_load     = 1'b0;
        dig_load_val = load_val;
        tc_d         = 1'b0;
        err_d        = 1'b0;
        if (load) begin
            if (load_ok) dig_load = 1'b1;
            else         err_d    = 1'b1;
        end else if (en) begin
            if (mode) begin
                if (count_w == MAX_BCD) begin
                    tc_d = 1'b1;
                    if (WRAP) begin
                        dig_load     = 1'b1;
                        dig_load_val = '0;
                    end
                end else begin
                    step_up = 1'b1;
                end
            end else begin
                if (count_w == '0) begin
                    tc_d = 1'b1;
                    if (WRAP) begin
                        dig_load     = 1'b1;
                        dig_load_val = MAX_BCD;
                    end
                end else begin
                    step_dn = 1'b1;
                end
            end
        end
    end

    assign inc_c[0] = step_up;
    assign dec_c[0] = step_dn;

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .rst_n      (reset),
            .inc        (inc_c[d]),
            .dec        (dec_c[d]),
            .load       (dig_load),
            .load_nib   (dig_load_val[4*d +: 4]),
            .nib        (count_w[4*d +: 4]),
            .carry_out  (inc_c[d+1]),
            .borrow_out (dec_c[d+1])
        );
    end

    // The top digit never carries or borrows out because the bounds are handled above.
    assign unused_chain = inc_c[DIGITS] ^ dec_c[DIGITS];

    // Segment decode of the current count with leading-zero blanking (digit 0 always shown).
    always_comb begin
        seg_d = '0;
        lead  = 1'b1;
        nib   = 4'd0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nib = count_w[4*d +: 4];
            if (BLANK && lead && d != 0 && nib == 4'd0) begin
                seg_d[8*d +: 8] = SEG_BLANK;
            end else begin
                seg_d[8*d +: 8] = seg7(nib);
                lead            = 1'b0;
            end
        end
    end

    // Status pulses and display register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tc_q  <= 1'b0;
            err_q <= 1'b0;
            seg_q <= SEG_RST;
        end else begin
            tc_q  <= tc_d;
            err_q <= err_d;
            seg_q <= seg_d;
        end
    end

    assign count = count_w;
    assign tc    = tc_q;
    assign err   = err_q;
    assign seg   = seg_q;

endmodule
